// File: rtl/rob_multiport.sv
// rob_multiport: reorder buffer with multi-port completion and multi-slot in-order retirement.
//
// A circular buffer of DEPTH entries. Dispatch allocates one entry per cycle at the tail.
// NUM_CDB writeback ports mark entries done. Up to RETIRE_W contiguous done entries retire
// from the head each cycle. A branch mispredict flushes every entry younger than the branch.
//
// Configuration macro: ROB_CDB_BYPASS_EN
//   When defined, a CDB hit in the current cycle counts as done for the retire window, so an
//   entry can complete and retire in the same cycle.
//   When undefined (default), retirement sees only registered done bits.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   alloc_valid/ready/tag       dispatch handshake; tag is the current tail
//   alloc_has_dest/pd_new/      per-entry payload from rename
//   pd_old/pc
//   cdb_valid/cdb_tag           completion strobes; port i tag at [i*TAG_W +: TAG_W]
//   br_mispredict(_tag)         branch FU mispredict report
//   mispredict(_tag)            registered one-cycle flush pulse to the front end
//   retire_valid/has_dest/      per-slot retirement info; valid bits are contiguous from bit 0
//   pd_old
//   head, count                 oldest entry tag and occupancy (0..DEPTH)

module rob_multiport #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TAG_W    = $clog2(DEPTH),
    parameter int unsigned PREG_W   = 7,
    parameter int unsigned NUM_CDB  = 4,
    parameter int unsigned RETIRE_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    output logic [TAG_W-1:0]           alloc_tag,
    input  logic                       alloc_has_dest,
    input  logic [PREG_W-1:0]          alloc_pd_new,
    input  logic [PREG_W-1:0]          alloc_pd_old,
    input  logic [31:0]                alloc_pc,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic                       br_mispredict,
    input  logic [TAG_W-1:0]           br_mispredict_tag,
    output logic                       mispredict,
    output logic [TAG_W-1:0]           mispredict_tag,
    output logic [RETIRE_W-1:0]        retire_valid,
    output logic [RETIRE_W-1:0]        retire_has_dest,
    output logic [RETIRE_W*PREG_W-1:0] retire_pd_old,
    output logic [TAG_W-1:0]           head,
    output logic [TAG_W:0]             count
);

    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

    // Control state
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic             mispredict_q;
    logic [TAG_W-1:0] mispredict_tag_q;

    // Entry payload; only read while the entry is valid, so it needs no reset
    logic [DEPTH-1:0]  has_dest_q;
    logic [PREG_W-1:0] pd_old_q [DEPTH];

    logic             alloc_fire;
    logic [DEPTH-1:0] cdb_hit;
    logic [DEPTH-1:0] done_eff;
    logic [DEPTH-1:0] keep;
    logic             flush_valid;
    logic [TAG_W-1:0] flush_age;
    logic [TAG_W:0]   ret_cnt;

    // The new mapping and PC travel with dispatch but nothing downstream of this block
    // consumes them.
    logic unused_alloc_fields;
    assign unused_alloc_fields = ^{alloc_pd_new, alloc_pc};

    // ------------------------------------------------------------------
    // Allocation
    // ------------------------------------------------------------------
    assign alloc_ready = (count_q != CNT_FULL) && !br_mispredict && !mispredict_q;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // ------------------------------------------------------------------
    // Completion: decode all CDB ports into one hit vector
    // ------------------------------------------------------------------
    always_comb begin
        cdb_hit = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            for (int unsigned p = 0; p < NUM_CDB; p++) begin
                if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    cdb_hit[e] = 1'b1;
                end
            end
        end
    end

`ifdef ROB_CDB_BYPASS_EN
    assign done_eff = done_q | cdb_hit;
`else
    assign done_eff = done_q;
`endif

    // ------------------------------------------------------------------
    // Flush: keep[e] marks entries at or older than the mispredicted branch.
    // Age is measured from head modulo DEPTH, so the comparison wraps correctly.
    // ------------------------------------------------------------------
    assign flush_valid = br_mispredict && valid_q[br_mispredict_tag];
    assign flush_age   = br_mispredict_tag - head_q;

    always_comb begin
        keep = '1;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (flush_valid && ((TAG_W'(e) - head_q) > flush_age)) begin
                keep[e] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Retire window: contiguous run of valid, done, surviving entries from head.
    // The keep term stops a younger-than-branch entry retiring in the flush cycle.
    // ------------------------------------------------------------------
    always_comb begin
        logic run;
        run             = 1'b1;
        ret_cnt         = '0;
        retire_valid    = '0;
        retire_has_dest = '0;
        retire_pd_old   = '0;
        for (int unsigned i = 0; i < RETIRE_W; i++) begin
            if (run && valid_q[head_q + TAG_W'(i)] && done_eff[head_q + TAG_W'(i)]
                    && keep[head_q + TAG_W'(i)]) begin
                retire_valid[i]                   = 1'b1;
                retire_has_dest[i]                = has_dest_q[head_q + TAG_W'(i)];
                retire_pd_old[i*PREG_W +: PREG_W] = pd_old_q[head_q + TAG_W'(i)];
                ret_cnt                           = ret_cnt + CNT_ONE;
            end else begin
                run = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state. Priority: CDB set, then retire/flush clear, then allocation.
    // A retired or flushed entry never coincides with the allocated tail slot
    // because allocation is blocked while full and during a flush.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q | (cdb_hit & valid_q & keep);

        for (int unsigned i = 0; i < RETIRE_W; i++) begin
            if (retire_valid[i]) begin
                valid_d[head_q + TAG_W'(i)] = 1'b0;
                done_d[head_q + TAG_W'(i)]  = 1'b0;
            end
        end

        if (flush_valid) begin
            valid_d = valid_d & keep;
            done_d  = done_d & keep;
        end

        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end

        head_d = head_q + ret_cnt[TAG_W-1:0];

        if (flush_valid) begin
            // Survivors are head..T inclusive, less whatever retires this cycle
            tail_d  = br_mispredict_tag + TAG_ONE;
            count_d = {1'b0, flush_age} + CNT_ONE - ret_cnt;
        end else begin
            tail_d  = alloc_fire ? (tail_q + TAG_ONE) : tail_q;
            count_d = count_q + (alloc_fire ? CNT_ONE : '0) - ret_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            valid_q          <= '0;
            done_q           <= '0;
            mispredict_q     <= 1'b0;
            mispredict_tag_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            mispredict_q <= flush_valid;
            if (flush_valid) begin
                mispredict_tag_q <= br_mispredict_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dest_q[tail_q] <= alloc_has_dest;
            pd_old_q[tail_q]   <= alloc_pd_old;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alloc_tag      = tail_q;
    assign mispredict     = mispredict_q;
    assign mispredict_tag = mispredict_tag_q;
    assign head           = head_q;
    assign count          = count_q;

endmodule
